visualizador_resta: RTL and testbench
=====================================

// Module: visualizador_resta
// PURPOSE
//  Downstream display stage for the 4-bit restador. Captures the difference
//  (suma) and carry/no-borrow flag (cout_co) on a load strobe. Converts them to
//  a signed decimal value (-16..+15) and drives a 4-digit multiplexed
//  7-segment display.
//  It sits between the restador outputs and the board display pins.
// PARAMETERS
//  REFRESH_DIV     50000  clk cycles per digit slot (>=2); tick at terminal count
//  SEG_ACTIVE_LOW  1      1: seg/an/dp active-low; 0: active-high
// PORTS
//  clk      in   1  system clock, rising edge
//  rst      in   1  asynchronous, active-high reset
//  suma     in   4  restador difference bits
//  cout_co  in   1  restador carry out; 1 = no borrow (result >= 0)
//  load     in   1  1-cycle strobe; capture suma/cout_co on this edge
//  an       out  4  digit enables; an[0]=units, an[1]=tens, an[2]=sign, an[3]=unused
//  seg      out  7  segments {g,f,e,d,c,b,a}
//  dp       out  1  decimal point, always off
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-high (clk, rst).
//    On rst: val_q=0, neg_q=0, prescaler=0, digit index=0.
//    All outputs go inactive at once: an all off, seg all off, dp off.
//    Outputs stay blank until the first refresh tick after reset release.
//  - Capture: at the rising clk edge with load=1: val_q<=suma, neg_q<=~cout_co.
//    No load: hold. The display uses the new value from the next tick onward.
//  - Magnitude is 5-bit: mag = neg_q ? (16 - val_q) : val_q, range 0..16.
//    suma=0 with cout_co=0 gives -16.
//  - Digits: units = mag % 10; tens = mag / 10 (0 or 1).
//    Tens is blank when 0 (leading-zero suppression).
//    Sign digit shows '-' (only g lit) when neg_q=1, else blank.
//    an[3] is always disabled.
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps. tick=1 at REFRESH_DIV-1.
//  - Digit index 0->1->2->3->0 advances on tick.
//  - an/seg are registered. On the edge where tick=1 they load the pattern for
//    the next index. Each digit is held exactly REFRESH_DIV cycles; no gap.
//  - Exactly one an bit is active at a time, except during the reset blank.
//  - load and tick on the same edge: the tick loads a pattern from the OLD
//    val_q. The new value appears on the following tick.
//  - Glyphs, active-high {g..a}: 0=0111111 1=0000110 2=1011011 3=1001111
//    4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111
//    '-'=1000000 blank=0000000.
//    SEG_ACTIVE_LOW=1 drives the bitwise inverse; the same applies to an and dp.
//  - rst asserted mid-scan: outputs blank on the next delta, not the next edge.
//    Captured value is lost. After reset with no load, the display shows "0".
// TESTING  (REFRESH_DIV=4, SEG_ACTIVE_LOW=1)
//  1. rst=1, then release with no load -> an=1111, seg=1111111, dp=1 until the
//     first tick; then scan shows units seg=1000000 ('0'), tens/sign blank.
//  2. Scan timing: free run -> an goes 1110,1101,1011,0111 and repeats.
//     Each value is held exactly 4 cycles.
//  3. load suma=0101, cout_co=1 -> units slot seg=0010010 ('5');
//     tens and sign slots seg=1111111.
//  4. load suma=1101, cout_co=0 (-3) -> units seg=0110000 ('3');
//     sign slot seg=0111111 ('-').
//  5. load suma=1100, cout_co=1 (+12) -> tens seg=1111001 ('1'),
//     units seg=0100100 ('2').
//     load suma=0000, cout_co=0 -> "-16": tens '1', units seg=0000010 ('6').
//  6. load coincident with tick -> the current slot shows the old value, the
//     next slot the new one. rst pulse mid-scan -> an=1111 with no clk edge.

Source files
------------

// File: rtl/visualizador_resta.sv
// rtl/visualizador_resta.sv - signed 4-digit multiplexed 7-segment display stage for the 4-bit restador
//
// Purpose: captures the restador difference/no-borrow flag on a load strobe,
// converts it to a signed decimal value -16..+15 and scans it onto a 4-digit
// multiplexed 7-segment display (units, tens, sign, unused slot).
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   suma     in   4  restador difference bits
//   cout_co  in   1  restador carry out, 1 = no borrow (result >= 0)
//   load     in   1  capture strobe for suma/cout_co
//   an       out  4  digit enables (an[0]=units, an[1]=tens, an[2]=sign, an[3]=unused)
//   seg      out  7  segments {g,f,e,d,c,b,a}
//   dp       out  1  decimal point, always off
module visualizador_resta #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] suma,
  input  logic       cout_co,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  logic [3:0]    val_q, val_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  // an/seg registers hold the active-high pattern; polarity is applied at the pins
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          tick;
  logic [4:0]    mag;
  logic [4:0]    mag_minus_ten;
  logic          tens_one;
  logic [3:0]    units;
  logic [1:0]    idx_next;

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  // Two's-complement view of {cout_co, suma}: negative results are 16 - suma,
  // so suma=0 with a borrow is -16.
  always_comb begin
    mag           = neg_q ? (5'd16 - {1'b0, val_q}) : {1'b0, val_q};
    tens_one      = (mag >= 5'd10);
    mag_minus_ten = mag - 5'd10;
    units         = tens_one ? mag_minus_ten[3:0] : mag[3:0];
  end

  always_comb begin
    val_d    = val_q;
    neg_d    = neg_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    an_d     = an_q;
    seg_d    = seg_q;
    idx_next = idx_q + 2'd1;

    if (load) begin
      val_d = suma;
      neg_d = ~cout_co;
    end

    if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Pattern uses the pre-load value, so a load coinciding with a tick shows
    // up from the following slot onward.
    if (tick) begin
      idx_d = idx_next;
      case (idx_next)
        2'd0: begin
          an_d  = 4'b0001;
          seg_d = glyph(units);
        end
        2'd1: begin
          an_d  = 4'b0010;
          seg_d = tens_one ? glyph(4'd1) : GLYPH_BLANK;
        end
        2'd2: begin
          an_d  = 4'b0100;
          seg_d = neg_q ? GLYPH_MINUS : GLYPH_BLANK;
        end
        default: begin
          an_d  = 4'b1000;
          seg_d = GLYPH_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q   <= '0;
      neg_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '0;
      seg_q   <= '0;
    end else begin
      val_q   <= val_d;
      neg_q   <= neg_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q  ^ {4{SEG_ACTIVE_LOW}};
  assign seg = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp  = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_visualizador_resta.sv
// tb/tb_visualizador_resta.sv - directed self-checking bench for visualizador_resta
module tb_visualizador_resta;

  logic       clk;
  logic       rst;
  logic [3:0] suma;
  logic       cout_co;
  logic       load;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_6     = 7'b0000010;
  localparam logic [6:0] S_8     = 7'b0000000;
  localparam logic [6:0] S_9     = 7'b0010000;

  visualizador_resta #(
    .REFRESH_DIV   (4),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .suma   (suma),
    .cout_co(cout_co),
    .load   (load),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic find_slot(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (an !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_slot_found"}, 32'(an), 32'(target));
  endtask

  task automatic show_check(input string tag, input logic [6:0] s_units,
                            input logic [6:0] s_tens, input logic [6:0] s_sign);
    find_slot(4'b1110, tag);
    check({tag, "_units"}, 32'(seg), 32'(s_units));
    check({tag, "_dp"}, 32'(dp), 32'd1);
    find_slot(4'b1101, tag);
    check({tag, "_tens"}, 32'(seg), 32'(s_tens));
    find_slot(4'b1011, tag);
    check({tag, "_sign"}, 32'(seg), 32'(s_sign));
    find_slot(4'b0111, tag);
    check({tag, "_unused"}, 32'(seg), 32'(S_BLANK));
  endtask

  task automatic do_load(input logic [3:0] s, input logic c);
    @(negedge clk);
    suma    = s;
    cout_co = c;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [3:0] prev_an;
    logic [3:0] exp_seq [5];
    int         cnt;

    exp_seq[0] = 4'b1011;
    exp_seq[1] = 4'b0111;
    exp_seq[2] = 4'b1110;
    exp_seq[3] = 4'b1101;
    exp_seq[4] = 4'b1011;

    rst     = 1'b1;
    load    = 1'b0;
    suma    = 4'd0;
    cout_co = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hf);
    check("rst_seg", 32'(seg), 32'(S_BLANK));
    check("rst_dp", 32'(dp), 32'd1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_tick_an", 32'(an), 32'hf);
    check("pre_tick_seg", 32'(seg), 32'(S_BLANK));
    @(negedge clk);
    check("first_tick_an", 32'(an), 32'b1101);
    check("first_tick_seg", 32'(seg), 32'(S_BLANK));

    for (int i = 0; i < 5; i++) begin
      prev_an = an;
      cnt     = 0;
      while (an === prev_an && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("hold_cycles", 32'(cnt), 32'd4);
      check("scan_order", 32'(an), 32'(exp_seq[i]));
      check("one_hot", 32'($countones(~an)), 32'd1);
    end

    show_check("reset_zero", S_0, S_BLANK, S_BLANK);

    do_load(4'b0101, 1'b1);
    show_check("plus5", S_5, S_BLANK, S_BLANK);
    do_load(4'b1101, 1'b0);
    show_check("minus3", S_3, S_BLANK, S_MINUS);
    do_load(4'b1100, 1'b1);
    show_check("plus12", S_2, S_1, S_BLANK);
    do_load(4'b1001, 1'b1);
    show_check("plus9", S_9, S_BLANK, S_BLANK);
    do_load(4'b0111, 1'b0);
    show_check("minus9", S_9, S_BLANK, S_MINUS);
    do_load(4'b1111, 1'b0);
    show_check("minus1", S_1, S_BLANK, S_MINUS);
    do_load(4'b1000, 1'b0);
    show_check("minus8", S_8, S_BLANK, S_MINUS);
    do_load(4'b0000, 1'b0);
    show_check("minus16", S_6, S_1, S_MINUS);

    // Load lands on the tick edge that opens the units slot.
    find_slot(4'b1011, "coinc_pre");
    find_slot(4'b0111, "coinc_align");
    repeat (3) @(negedge clk);
    suma    = 4'b0101;
    cout_co = 1'b1;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("coinc_units_an", 32'(an), 32'b1110);
    check("coinc_units_old", 32'(seg), 32'(S_6));
    find_slot(4'b1101, "coinc_tens");
    check("coinc_tens_new", 32'(seg), 32'(S_BLANK));
    find_slot(4'b1011, "coinc_sign");
    check("coinc_sign_new", 32'(seg), 32'(S_BLANK));
    find_slot(4'b1110, "coinc_units2");
    check("coinc_units_new", 32'(seg), 32'(S_5));

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'hf);
    check("async_rst_seg", 32'(seg), 32'(S_BLANK));
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    show_check("post_rst_zero", S_0, S_BLANK, S_BLANK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
